// File: rtl/alu_src_sequencer_if.sv
// Control/status bundle between the multicycle ALU sequencer (master) and the datapath (slave).
interface alu_src_sequencer_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic [1:0] alu_src_a;
  logic [3:0] alu_src_b;
  logic [2:0] alu_op;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_src;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       aluout_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       epc_write;
  logic [3:0] state_out;

  modport master (
    input  opcode, funct, zero, overflow,
    output alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, pc_src,
           mem_read, mem_write, iord, ir_write, aluout_write,
           reg_write, reg_dst, mem_to_reg, epc_write, state_out
  );

  modport slave (
    output opcode, funct, zero, overflow,
    input  alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, pc_src,
           mem_read, mem_write, iord, ir_write, aluout_write,
           reg_write, reg_dst, mem_to_reg, epc_write, state_out
  );
endinterface

// File: rtl/alu_src_sequencer.sv
// Moore control FSM sequencing the shared ALU of a multicycle datapath.
// Define ALU_OVF_EXC_EN to trap signed overflow and illegal opcodes/functs to the EXC state.
module alu_src_sequencer #(
  parameter int MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_src_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_EXEC_I = 4'd5,
    S_WB_I   = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_WB_MEM = 4'd9,
    S_MEM_WR = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
`ifdef ALU_OVF_EXC_EN
    , S_EXC  = 4'd13
`endif
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

`ifdef ALU_OVF_EXC_EN
  localparam state_t S_ILL = S_EXC;
`else
  localparam state_t S_ILL = S_FETCH;
`endif

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cnt_last;
  logic       ovf_trap;

  assign cnt_last = (cnt_q == CNT_LAST);

`ifdef ALU_OVF_EXC_EN
  assign ovf_trap = bus.overflow;
  logic unused_in;
  assign unused_in = bus.zero;
`else
  assign ovf_trap = 1'b0;
  logic unused_in;
  assign unused_in = ^{bus.zero, bus.overflow};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = '0;
    bus.alu_src_a     = 2'd0;
    bus.alu_src_b     = 4'd0;
    bus.alu_op        = OP_ADD;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = 2'b00;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.iord          = 1'b0;
    bus.ir_write      = 1'b0;
    bus.aluout_write  = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.epc_write     = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      // The same counter paces both memory-read states; it rests at 0 elsewhere.
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 4'd1;
        if (cnt_last) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = S_DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_DECODE: begin
        bus.alu_src_b    = 4'd3;
        bus.aluout_write = 1'b1;
        case (bus.opcode)
          6'h00:        state_d = S_EXEC_R;
          6'h08:        state_d = S_EXEC_I;
          6'h23, 6'h2B: state_d = S_ADDR;
          6'h04:        state_d = S_BRANCH;
          6'h02:        state_d = S_JUMP;
          default:      state_d = S_ILL;
        endcase
      end

      S_EXEC_R: begin
        bus.alu_src_a    = 2'd1;
        bus.aluout_write = 1'b1;
        state_d          = S_WB_R;
        case (bus.funct)
          6'h20: begin bus.alu_op = OP_ADD; if (ovf_trap) state_d = S_ILL; end
          6'h22: begin bus.alu_op = OP_SUB; if (ovf_trap) state_d = S_ILL; end
          6'h24: bus.alu_op = OP_AND;
          6'h25: bus.alu_op = OP_OR;
          6'h2A: bus.alu_op = OP_SLT;
          default: state_d = S_ILL;
        endcase
      end

      S_WB_R: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        state_d       = S_FETCH;
      end

      S_EXEC_I: begin
        bus.alu_src_a    = 2'd1;
        bus.alu_src_b    = 4'd2;
        bus.aluout_write = 1'b1;
        state_d          = ovf_trap ? S_ILL : S_WB_I;
      end

      S_WB_I: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end

      S_ADDR: begin
        bus.alu_src_a    = 2'd1;
        bus.alu_src_b    = 4'd2;
        bus.aluout_write = 1'b1;
        state_d          = (bus.opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (cnt_last) state_d = S_WB_MEM;
        else          cnt_d   = cnt_q + 4'd1;
      end

      S_WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = S_FETCH;
      end

      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        state_d       = S_FETCH;
      end

      S_BRANCH: begin
        bus.alu_src_a     = 2'd1;
        bus.alu_op        = OP_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = 2'b01;
        state_d           = S_FETCH;
      end

      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b10;
        state_d      = S_FETCH;
      end

`ifdef ALU_OVF_EXC_EN
      S_EXC: begin
        bus.epc_write = 1'b1;
        bus.pc_write  = 1'b1;
        bus.pc_src    = 2'b11;
        state_d       = S_FETCH;
      end
`endif

      default: state_d = S_RESET;
    endcase
  end

  assign bus.state_out = state_q;

endmodule

// File: tb/tb_alu_src_sequencer.sv
// Cycle-by-cycle check of the ALU sequencer at MEM_LAT=1 and MEM_LAT=3 against a stimulus/expect table.
module tb_alu_src_sequencer;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcs;
    logic       mr;
    logic       mw;
    logic       iord;
    logic       irw;
    logic       aow;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       epc;
  } out_t;

  typedef struct packed {
    logic       d3;
    logic       r;
    logic [5:0] opc;
    logic [5:0] fn;
    logic       ovf;
    out_t       x;
  } cyc_t;

  logic clk = 1'b0;
  logic reset1 = 1'b1;
  logic reset3 = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic zero = 1'b0;
  logic overflow = 1'b0;

  alu_src_sequencer_if if1 ();
  alu_src_sequencer_if if3 ();

  assign if1.opcode = opcode;  assign if3.opcode = opcode;
  assign if1.funct = funct;    assign if3.funct = funct;
  assign if1.zero = zero;      assign if3.zero = zero;
  assign if1.overflow = overflow; assign if3.overflow = overflow;

  alu_src_sequencer #(.MEM_LAT(1)) u_dut1 (.clk(clk), .reset(reset1), .bus(if1));
  alu_src_sequencer #(.MEM_LAT(3)) u_dut3 (.clk(clk), .reset(reset3), .bus(if3));

  always #5 clk = ~clk;

  out_t act1, act3;
  assign act1 = {if1.state_out, if1.alu_src_a, if1.alu_src_b, if1.alu_op, if1.pc_write,
                 if1.pc_write_cond, if1.pc_src, if1.mem_read, if1.mem_write, if1.iord,
                 if1.ir_write, if1.aluout_write, if1.reg_write, if1.reg_dst, if1.mem_to_reg,
                 if1.epc_write};
  assign act3 = {if3.state_out, if3.alu_src_a, if3.alu_src_b, if3.alu_op, if3.pc_write,
                 if3.pc_write_cond, if3.pc_src, if3.mem_read, if3.mem_write, if3.iord,
                 if3.ir_write, if3.aluout_write, if3.reg_write, if3.reg_dst, if3.mem_to_reg,
                 if3.epc_write};

  out_t x_rst, x_f, x_fl, x_dec, x_rA, x_rS, x_rN, x_rO, x_rL, x_wbr, x_ei, x_wbi;
  out_t x_addr, x_mrd, x_wbm, x_mwr, x_br, x_jmp, x_exc;

  cyc_t tbl[$];
  out_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic       cur_d3;
  logic [5:0] cur_opc, cur_fn;
  logic       cur_ovf;

  function automatic out_t o(input int st);
    out_t v;
    v = '0;
    v.st = 4'(st);
    return v;
  endfunction

  task automatic chk(input string nm, input out_t got, input out_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic e(input out_t x);
    tbl.push_back({cur_d3, 1'b0, cur_opc, cur_fn, cur_ovf, x});
  endtask

  task automatic er(input logic r);
    tbl.push_back({cur_d3, r, cur_opc, cur_fn, cur_ovf, x_rst});
  endtask

  // New instruction: fetch cycles for this DUT's latency, then decode.
  task automatic op(input logic [5:0] opc, input logic [5:0] fn, input logic ovf);
    cur_opc = opc; cur_fn = fn; cur_ovf = ovf;
    for (int k = 0; k < (cur_d3 ? 2 : 0); k++) e(x_f);
    e(x_fl);
    e(x_dec);
  endtask

  initial begin
    x_rst = o(0);
    x_f   = o(1);  x_f.b = 4'd1; x_f.mr = 1'b1;
    x_fl  = x_f;   x_fl.irw = 1'b1; x_fl.pcw = 1'b1;
    x_dec = o(2);  x_dec.b = 4'd3; x_dec.aow = 1'b1;
    x_rA  = o(3);  x_rA.a = 2'd1; x_rA.aow = 1'b1;
    x_rS  = x_rA;  x_rS.op = 3'b001;
    x_rN  = x_rA;  x_rN.op = 3'b010;
    x_rO  = x_rA;  x_rO.op = 3'b011;
    x_rL  = x_rA;  x_rL.op = 3'b111;
    x_wbr = o(4);  x_wbr.rw = 1'b1; x_wbr.rd = 1'b1;
    x_ei  = o(5);  x_ei.a = 2'd1; x_ei.b = 4'd2; x_ei.aow = 1'b1;
    x_wbi = o(6);  x_wbi.rw = 1'b1;
    x_addr = o(7); x_addr.a = 2'd1; x_addr.b = 4'd2; x_addr.aow = 1'b1;
    x_mrd = o(8);  x_mrd.mr = 1'b1; x_mrd.iord = 1'b1;
    x_wbm = o(9);  x_wbm.rw = 1'b1; x_wbm.m2r = 1'b1;
    x_mwr = o(10); x_mwr.mw = 1'b1; x_mwr.iord = 1'b1;
    x_br  = o(11); x_br.a = 2'd1; x_br.op = 3'b001; x_br.pcwc = 1'b1; x_br.pcs = 2'b01;
    x_jmp = o(12); x_jmp.pcw = 1'b1; x_jmp.pcs = 2'b10;
    x_exc = o(13); x_exc.epc = 1'b1; x_exc.pcw = 1'b1; x_exc.pcs = 2'b11;

    // MEM_LAT=1 instance
    cur_d3 = 1'b0; cur_opc = '0; cur_fn = '0; cur_ovf = 1'b0;
    er(1'b1); er(1'b0);
    op(6'h00, 6'h20, 1'b0); e(x_rA); e(x_wbr);
    op(6'h00, 6'h22, 1'b0); e(x_rS); e(x_wbr);
    op(6'h00, 6'h24, 1'b0); e(x_rN); e(x_wbr);
    op(6'h00, 6'h25, 1'b0); e(x_rO); e(x_wbr);
    op(6'h00, 6'h2A, 1'b0); e(x_rL); e(x_wbr);
    op(6'h00, 6'h24, 1'b1); e(x_rN); e(x_wbr);
    op(6'h00, 6'h22, 1'b1); e(x_rS);
`ifdef ALU_OVF_EXC_EN
    e(x_exc);
`else
    e(x_wbr);
`endif
    op(6'h00, 6'h3F, 1'b0); e(x_rA);
`ifdef ALU_OVF_EXC_EN
    e(x_exc);
`endif
    op(6'h23, 6'h00, 1'b0); e(x_addr); e(x_mrd); e(x_wbm);
    op(6'h2B, 6'h00, 1'b0); e(x_addr); e(x_mwr);
    op(6'h04, 6'h00, 1'b0); e(x_br);
    op(6'h02, 6'h00, 1'b0); e(x_jmp);
    op(6'h08, 6'h00, 1'b1); e(x_ei);
`ifdef ALU_OVF_EXC_EN
    e(x_exc);
`else
    e(x_wbi);
`endif
    op(6'h08, 6'h00, 1'b0); e(x_ei); e(x_wbi);
    op(6'h3F, 6'h00, 1'b0);
`ifdef ALU_OVF_EXC_EN
    e(x_exc);
`endif
    e(x_fl);

    // MEM_LAT=3 instance: reset mid-FETCH, then sub and lw
    cur_d3 = 1'b1; cur_opc = '0; cur_fn = '0; cur_ovf = 1'b0;
    er(1'b1); er(1'b0); e(x_f); e(x_f);
    er(1'b1); er(1'b0);
    op(6'h00, 6'h22, 1'b0); e(x_rS); e(x_wbr);
    op(6'h23, 6'h00, 1'b0); e(x_addr); e(x_mrd); e(x_mrd); e(x_mrd); e(x_wbm);
    e(x_f);

    foreach (tbl[i]) begin
      @(negedge clk);
      opcode   = tbl[i].opc;
      funct    = tbl[i].fn;
      overflow = tbl[i].ovf;
      zero     = 1'($urandom_range(0, 1));
      reset1   = tbl[i].d3 ? 1'b1 : tbl[i].r;
      reset3   = tbl[i].d3 ? tbl[i].r : 1'b1;
      sb.push_back(tbl[i].x);
      #1;
      chk($sformatf("step%0d_lat%0d", i, tbl[i].d3 ? 3 : 1), tbl[i].d3 ? act3 : act1, sb.pop_front());
    end

    // Asynchronous reset landing mid-cycle inside MEM_RD of a load
    @(negedge clk);
    reset3 = 1'b1; opcode = 6'h23; funct = '0; overflow = 1'b0; reset1 = 1'b1;
    @(negedge clk);
    reset1 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("lw_mem_rd_before_abort", act1, x_mrd);
    reset1 = 1'b1;
    #1;
    chk("lw_async_abort", act1, x_rst);
    @(negedge clk);
    chk("lw_abort_held", act1, x_rst);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_src_sequencer.md
Name: alu_src_sequencer

Overview:
- Multicycle control FSM that sequences the shared ALU: PC increment, branch-target precompute, R-type, immediate, address and compare operations.
- Drives the ALU A-source mux, the ALU B-source mux (4-bit selector) and the ALU op code.
- Also drives the PC, IR, memory, ALUOut and register-file write enables.
- Sits between the instruction register fields (opcode/funct, ALU flags) and the datapath muxes/registers.

Parameters:
- MEM_LAT, 1: memory access latency in cycles for fetch and load, range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed-overflow flag
- alu_src_a  out  2  0=PC, 1=reg A
- alu_src_b  out  4  0=reg B, 1=constant 4, 2=sign-ext imm, 3=sign-ext imm<<2, others unused
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 111 SLT
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load when zero=1
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector
- mem_read, mem_write  out  1 each  memory strobes
- iord  out  1  0=PC address, 1=ALUOut address
- ir_write  out  1  IR load
- aluout_write  out  1  ALUOut load
- reg_write, reg_dst, mem_to_reg  out  1 each  register-file controls (reg_dst 1=rd)
- epc_write  out  1  EPC load
- state_out  out  4  current state code, debug

Behaviour:
- Moore FSM; all outputs decode combinationally from state and the latency counter.
- In any state, every output not listed for that state is 0.
- Reset: async to state RESET (code 0). All outputs 0, latency counter 0. The first clk edge after reset deasserts goes to FETCH.
- Reset mid-operation aborts immediately with no partial writes beyond the current cycle.
- FETCH (1): mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, ADD.
  - Counter counts 0..MEM_LAT-1.
  - On the cycle cnt==MEM_LAT-1: ir_write=1, pc_write=1, pc_src=00, then go to DECODE. Counter clears on exit.
- DECODE (2): alu_src_a=0, alu_src_b=3, ADD, aluout_write=1. Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x08 -> EXEC_I
  - 0x23 or 0x2B -> ADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - otherwise -> ILLEGAL path
- EXEC_R (3): alu_src_a=1, alu_src_b=0, aluout_write=1. alu_op by funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. Next WB_R; unknown funct -> ILLEGAL path.
- WB_R (4): reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- EXEC_I (5): alu_src_a=1, alu_src_b=2, ADD, aluout_write=1 -> WB_I.
- WB_I (6): reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- ADDR (7): alu_src_a=1, alu_src_b=2, ADD, aluout_write=1 -> MEM_RD if opcode 0x23, else MEM_WR.
- MEM_RD (8): mem_read=1, iord=1 for MEM_LAT cycles (same counter rule as FETCH) -> WB_MEM.
- WB_MEM (9): reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WR (10): mem_write=1, iord=1 for exactly one cycle -> FETCH.
- BRANCH (11): alu_src_a=1, alu_src_b=0, SUB, pc_write_cond=1, pc_src=01 -> FETCH.
- JUMP (12): pc_write=1, pc_src=10 -> FETCH.
- ILLEGAL path without the feature: go to FETCH with no writes.
- Opcode/funct are sampled only in DECODE/EXEC_R/ADDR; the IR is stable until the next FETCH.
- Cycle counts with MEM_LAT=1: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3.

Optional Feature:
- Macro: ALU_OVF_EXC_EN.
- Defined:
  - In EXEC_R with funct 0x20/0x22, or in EXEC_I: overflow=1 sends the next state to EXC (13) instead of WB.
  - ILLEGAL path also goes to EXC.
  - EXC: epc_write=1, pc_write=1, pc_src=11 for one cycle, then FETCH.
- Undefined: overflow ignored, EXC state absent, epc_write tied 0.

Test Plan:
- Assert reset mid-FETCH, release -> all outputs 0 and state_out=0 for one cycle; FETCH next with alu_src_b=1, alu_op=000, mem_read=1.
- MEM_LAT=3, opcode 0x00 funct 0x22 -> FETCH lasts 3 cycles with ir_write only on the 3rd; EXEC_R shows alu_src_a=1, alu_src_b=0, alu_op=001; WB_R reg_write=1, reg_dst=1; 6 cycles total.
- opcode 0x23 then 0x2B with MEM_LAT=1 -> ADDR alu_src_b=2; lw gives MEM_RD iord=1 then WB_MEM mem_to_reg=1 (5 cycles); sw gives a single mem_write=1 cycle (4 cycles).
- opcode 0x04 -> DECODE alu_src_b=3, aluout_write=1; BRANCH alu_op=001, pc_write_cond=1, pc_src=01; opcode 0x02 -> pc_write=1, pc_src=10.
- opcode 0x08 with overflow=1 in EXEC_I -> with ALU_OVF_EXC_EN: EXC, epc_write=1, pc_src=11, no reg_write; without: WB_I reg_write=1.
- opcode 0x3F -> with macro: EXC; without: returns to FETCH, no write strobes asserted.
